// File: rtl/linebuffer_pkg.sv
// -----------------------------------------------------------------------------
// linebuffer_pkg
// Shared types and widths for the scanline buffer draw-side logic.
//   lb_state_t : draw sequencer state (IDLE / CLEAR / DRAW / DONE)
//   LB_ADDR_W  : line buffer address width ({bank, x})
//   LB_X_W     : pixel x coordinate width
//   colour_t   : 8-bit palette colour
// -----------------------------------------------------------------------------
package linebuffer_pkg;

    localparam int LB_ADDR_W = 11;
    localparam int LB_X_W    = 10;

    typedef logic [7:0] colour_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAW,
        DONE
    } lb_state_t;

endpackage

// File: rtl/linebuffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// linebuffer_ctrl_if
// Drawer <-> line buffer controller handshake.
//   draw_valid  : drawer pixel valid
//   draw_ready  : controller accepts the pixel
//   draw_x      : pixel x coordinate
//   draw_colour : pixel colour
//   draw_done   : pulse, drawer finished the current line
//   line_req    : pulse, drawer may start rendering the next line
// master = drawer, slave = controller.
// -----------------------------------------------------------------------------
interface linebuffer_ctrl_if;
    import linebuffer_pkg::*;

    logic              draw_valid;
    logic              draw_ready;
    logic [LB_X_W-1:0] draw_x;
    colour_t           draw_colour;
    logic              draw_done;
    logic              line_req;

    modport master (
        output draw_valid,
        output draw_x,
        output draw_colour,
        output draw_done,
        input  draw_ready,
        input  line_req
    );

    modport slave (
        input  draw_valid,
        input  draw_x,
        input  draw_colour,
        input  draw_done,
        output draw_ready,
        output line_req
    );

endinterface

// File: rtl/linebuffer_ctrl.sv
// -----------------------------------------------------------------------------
// linebuffer_ctrl
// Draw-side sequencer for the double-buffered scanline buffer. Ping-pongs the
// two 1024-entry halves: the draw bank is cleared to the background colour,
// then filled by the drawer, while the other bank is scanned out.
//
// Ports:
//   clk_draw, rst_draw : draw clock, asynchronous active-high reset
//   drw (slave)        : drawer handshake (valid/ready/x/colour/done/line_req)
//   line_start         : single-cycle pulse, requests a bank swap
//   bg_colour          : background colour, sampled on line_start
//   bank_pix           : bank read by the pixel side (addr_pix[10])
//   addr_draw, we_draw, colour_draw : registered BRAM write port
//   overrun            : pulse, a line was swapped while unfinished
//   overrun_cnt        : saturating overrun count
// -----------------------------------------------------------------------------
module linebuffer_ctrl
    import linebuffer_pkg::*;
#(
    parameter int unsigned LINE_W      = 640,
    parameter colour_t     TRANSPARENT = 8'h00
) (
    input  logic                 clk_draw,
    input  logic                 rst_draw,
    linebuffer_ctrl_if.slave     drw,
    input  logic                 line_start,
    input  colour_t              bg_colour,
    output logic                 bank_pix,
    output logic [LB_ADDR_W-1:0] addr_draw,
    output logic                 we_draw,
    output colour_t              colour_draw,
    output logic                 overrun,
    output logic [7:0]           overrun_cnt
);

    localparam logic [LB_X_W-1:0] CLR_LAST = LB_X_W'(LINE_W - 1);
    localparam logic [LB_X_W:0]   X_LIMIT  = (LB_X_W + 1)'(LINE_W);

    lb_state_t r_state;
    lb_state_t w_state_nxt;

    logic              r_bank_draw;
    colour_t           r_bg;
    logic [LB_X_W-1:0] r_clr_x;
    logic              r_we;
    logic [LB_ADDR_W-1:0] r_addr;
    colour_t           r_colour;
    logic              r_line_req;
    logic              r_overrun;
    logic [7:0]        r_overrun_cnt;

    logic w_clr_last;
    logic w_draw_ready;
    logic w_clr_we;
    logic w_pix_we;
    logic w_ovr;
    logic w_line_req_set;

    assign w_clr_last = (r_clr_x == CLR_LAST);

    // State register
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a swap request overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        if (line_start) begin
            w_state_nxt = CLEAR;
        end else begin
            case (r_state)
                CLEAR:   if (w_clr_last)     w_state_nxt = DRAW;
                DRAW:    if (drw.draw_done)  w_state_nxt = DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Output / strobe logic. Both write sources are suppressed in the
    // line_start cycle so nothing lands in the bank being handed over.
    always_comb begin
        w_draw_ready   = (r_state == DRAW) && !line_start;
        w_clr_we       = (r_state == CLEAR) && !line_start;
        w_pix_we       = drw.draw_valid && w_draw_ready
                         && (drw.draw_colour != TRANSPARENT)
                         && ({1'b0, drw.draw_x} < X_LIMIT);
        w_ovr          = line_start
                         && ((r_state == CLEAR)
                             || ((r_state == DRAW) && !drw.draw_done));
        w_line_req_set = (r_state == CLEAR) && w_clr_last && !line_start;
    end

    // Datapath: bank, clear counter, write port, overrun bookkeeping
    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            r_bank_draw   <= 1'b0;
            r_bg          <= '0;
            r_clr_x       <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_colour      <= '0;
            r_line_req    <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= '0;
        end else begin
            r_we       <= w_clr_we | w_pix_we;
            r_line_req <= w_line_req_set;
            r_overrun  <= w_ovr;

            if (w_clr_we) begin
                r_addr   <= {r_bank_draw, r_clr_x};
                r_colour <= r_bg;
            end else if (w_pix_we) begin
                r_addr   <= {r_bank_draw, drw.draw_x};
                r_colour <= drw.draw_colour;
            end

            if (line_start) begin
                r_bank_draw <= ~r_bank_draw;
                r_bg        <= bg_colour;
                r_clr_x     <= '0;
            end else if (w_clr_we) begin
                r_clr_x     <= r_clr_x + 1'b1;
            end

            if (w_ovr && (r_overrun_cnt != '1)) begin
                r_overrun_cnt <= r_overrun_cnt + 1'b1;
            end
        end
    end

    assign drw.draw_ready = w_draw_ready;
    assign drw.line_req   = r_line_req;
    assign bank_pix       = ~r_bank_draw;
    assign addr_draw      = r_addr;
    assign we_draw        = r_we;
    assign colour_draw    = r_colour;
    assign overrun        = r_overrun;
    assign overrun_cnt    = r_overrun_cnt;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_linebuffer_ctrl
// Scoreboard bench for linebuffer_ctrl with LINE_W=8. The stimulus task
// predicts, from cycle offsets relative to the last line_start, which writes,
// line_req pulses, overruns, bank flips and ready levels should appear and
// queues them with the cycle they are due; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_linebuffer_ctrl;
    import linebuffer_pkg::*;

    localparam int      LW    = 8;
    localparam colour_t TRANS = 8'h00;

    typedef struct {
        int          cyc;
        logic [10:0] a;
        logic [7:0]  d;
    } ev_t;

    logic        clk_draw = 1'b0;
    logic        rst_draw;
    logic        line_start;
    colour_t     bg_colour;
    logic        bank_pix;
    logic [10:0] addr_draw;
    logic        we_draw;
    colour_t     colour_draw;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    linebuffer_ctrl_if drw_if();

    linebuffer_ctrl #(
        .LINE_W      (LW),
        .TRANSPARENT (TRANS)
    ) dut (
        .clk_draw    (clk_draw),
        .rst_draw    (rst_draw),
        .drw         (drw_if),
        .line_start  (line_start),
        .bg_colour   (bg_colour),
        .bank_pix    (bank_pix),
        .addr_draw   (addr_draw),
        .we_draw     (we_draw),
        .colour_draw (colour_draw),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk_draw = ~clk_draw;

    int cyc = 0;
    always @(posedge clk_draw) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    ev_t wq[$];   // writes
    ev_t lq[$];   // line_req pulses
    ev_t oq[$];   // overrun pulses (d = expected count)
    ev_t bq[$];   // bank_pix after a swap (d[0])
    ev_t rq[$];   // draw_ready level (d[0])

    // Reference model of the line: when it started and whether it finished
    bit      m_active;
    bit      m_done;
    bit      m_bank;
    int      m_e;
    colour_t m_bg;
    int      m_cnt;

    function automatic ev_t mk(input int c, input logic [10:0] a, input logic [7:0] d);
        ev_t e;
        e.cyc = c;
        e.a   = a;
        e.d   = d;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_bank   = 0;
        m_e      = 0;
        m_bg     = '0;
        m_cnt    = 0;
        wq.delete();
        lq.delete();
        oq.delete();
        bq.delete();
        rq.delete();
    endtask

    // Drive one cycle of inputs and queue what it should cause.
    // Line started at edge m_e: clear x happens in cycle m_e+x, drawing
    // is open from cycle m_e+LW until draw_done or the next swap.
    task automatic step(input bit ls, input colour_t bg, input bit v,
                        input int x, input colour_t col, input bit dn);
        int c;
        int n;
        bit clearing;
        bit drawing;
        bit rdy;
        line_start         = ls;
        bg_colour          = bg;
        drw_if.draw_valid  = v;
        drw_if.draw_x      = x[9:0];
        drw_if.draw_colour = col;
        drw_if.draw_done   = dn;
        c = cyc;
        n = c + 1;
        clearing = m_active && ((c - m_e) < LW);
        drawing  = m_active && !clearing && !m_done;
        rdy      = drawing && !ls;
        rq.push_back(mk(c, '0, {7'b0, rdy}));
        if (clearing && !ls) begin
            wq.push_back(mk(n, {m_bank, 10'(c - m_e)}, m_bg));
            if ((c - m_e) == LW - 1) lq.push_back(mk(n, '0, '0));
        end
        if (rdy && v && (col != TRANS) && (x < LW))
            wq.push_back(mk(n, {m_bank, 10'(x)}, col));
        if (drawing && dn && !ls) m_done = 1;
        if (ls) begin
            if (clearing || (drawing && !dn)) begin
                if (m_cnt < 255) m_cnt++;
                oq.push_back(mk(n, '0, 8'(m_cnt)));
            end
            m_bank   = !m_bank;
            m_bg     = bg;
            m_e      = n;
            m_active = 1;
            m_done   = 0;
            bq.push_back(mk(n, '0, {7'b0, !m_bank}));
        end
        @(posedge clk_draw);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, '0, 0, 0, '0, 0);
    endtask

    // Monitor: compares DUT outputs against the queued expectations
    always @(negedge clk_draw) begin
        if (!rst_draw) begin
            if (we_draw) begin
                if (wq.size() == 0 || wq[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected cyc=%0d got addr=%0h data=%0h", cyc, addr_draw, colour_draw);
                end else begin
                    chk("write_addr", int'(addr_draw), int'(wq[0].a));
                    chk("write_data", int'(colour_draw), int'(wq[0].d));
                    void'(wq.pop_front());
                end
            end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
                checks++;
                errors++;
                $display("FAIL write_missing cyc=%0d got we=0 expected addr=%0h data=%0h", cyc, wq[0].a, wq[0].d);
                void'(wq.pop_front());
            end

            if (drw_if.line_req) begin
                if (lq.size() == 0 || lq[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL line_req_unexpected cyc=%0d got=1 expected=0", cyc);
                end else begin
                    chk("line_req", 1, 1);
                    void'(lq.pop_front());
                end
            end else if (lq.size() > 0 && lq[0].cyc == cyc) begin
                chk("line_req_missing", 0, 1);
                void'(lq.pop_front());
            end

            if (overrun) begin
                if (oq.size() == 0 || oq[0].cyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL overrun_unexpected cyc=%0d got=1 expected=0", cyc);
                end else begin
                    chk("overrun_cnt", int'(overrun_cnt), int'(oq[0].d));
                    void'(oq.pop_front());
                end
            end else if (oq.size() > 0 && oq[0].cyc == cyc) begin
                chk("overrun_missing", 0, 1);
                void'(oq.pop_front());
            end

            if (bq.size() > 0 && bq[0].cyc == cyc) begin
                chk("bank_pix", int'(bank_pix), int'(bq[0].d[0]));
                void'(bq.pop_front());
            end

            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                chk("draw_ready", int'(drw_if.draw_ready), int'(rq[0].d[0]));
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_draw           = 1'b1;
        line_start         = 1'b0;
        bg_colour          = '0;
        drw_if.draw_valid  = 1'b0;
        drw_if.draw_x      = '0;
        drw_if.draw_colour = '0;
        drw_if.draw_done   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_draw);
        #3;
        rst_draw = 1'b0;

        chk("rst_bank_pix",    int'(bank_pix), 1);
        chk("rst_we_draw",     int'(we_draw), 0);
        chk("rst_addr_draw",   int'(addr_draw), 0);
        chk("rst_colour_draw", int'(colour_draw), 0);
        chk("rst_line_req",    int'(drw_if.line_req), 0);
        chk("rst_overrun",     int'(overrun), 0);
        chk("rst_overrun_cnt", int'(overrun_cnt), 0);
        chk("rst_draw_ready",  int'(drw_if.draw_ready), 0);

        @(posedge clk_draw);
        #1;

        // First line: clear with 8'h11 into bank 1
        step(1, 8'h11, 0, 0, '0, 0);
        idle(LW);
        // Drawer pixels: one visible, one transparent, one off-line
        step(0, '0, 1, 3, 8'h2A, 0);
        step(0, '0, 1, 5, 8'h00, 0);
        step(0, '0, 1, 9, 8'h33, 0);
        // Normal swap
        step(0, '0, 0, 0, '0, 1);
        idle(2);
        step(1, 8'h22, 0, 0, '0, 0);
        idle(LW + 2);
        // Overrun in DRAW with valid held
        step(0, '0, 1, 1, 8'h44, 0);
        step(1, 8'h55, 1, 2, 8'h45, 0);
        idle(3);
        // Swap during CLEAR
        step(1, 8'h66, 0, 0, '0, 0);
        idle(LW + 4);
        // Simultaneous swap and draw_done: no overrun
        step(1, 8'h77, 1, 4, 8'h12, 1);
        idle(LW + 2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            colour_t col;
            col = ($urandom_range(0, 3) == 0) ? 8'h00 : colour_t'($urandom_range(1, 255));
            step($urandom_range(0, 29) == 0, colour_t'($urandom), $urandom_range(0, 9) < 7,
                 int'($urandom_range(0, LW + 1)), col, $urandom_range(0, 19) == 0);
        end
        idle(LW + 2);

        // Saturation: back-to-back swaps
        for (int i = 0; i < 260; i++) step(1, 8'h5A, 0, 0, '0, 0);
        idle(LW + 2);
        chk("overrun_cnt_sat", int'(overrun_cnt), m_cnt);
        chk("overrun_cnt_sat_255", int'(overrun_cnt), 255);

        // Asynchronous reset in the middle of a clear
        step(1, 8'h99, 0, 0, '0, 0);
        idle(3);
        #2;
        chk("pre_rst_we_draw", int'(we_draw), 1);
        rst_draw = 1'b1;
        #1;
        chk("async_rst_we_draw", int'(we_draw), 0);
        chk("async_rst_overrun_cnt", int'(overrun_cnt), 0);
        chk("async_rst_bank_pix", int'(bank_pix), 1);
        model_reset();
        repeat (2) @(posedge clk_draw);
        #3;
        rst_draw = 1'b0;
        @(posedge clk_draw);
        #1;
        idle(LW + 4);

        // A clean line after reset
        step(1, 8'hC3, 0, 0, '0, 0);
        idle(LW);
        step(0, '0, 1, 7, 8'hE1, 0);
        step(0, '0, 0, 0, '0, 1);
        idle(3);

        chk("pending_writes", wq.size(), 0);
        chk("pending_line_req", lq.size(), 0);
        chk("pending_overrun", oq.size(), 0);
        chk("pending_bank", bq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/linebuffer_ctrl.md
# linebuffer_ctrl

Draw-side sequencer for the double-buffered scanline buffer. It ping-pongs the two 1024-entry halves of `linebuffer_bram`: one half is scanned out while the other is cleared to the background colour and then filled by the sprite/tile drawer. It arbitrates the single write port between the clear engine and drawer writes. It also drops transparent pixels and flags lines the drawer failed to finish before the next scanline.

## Interface
Parameters:
- `LINE_W`, default 640: visible pixels per line. This is the clear length and the valid x range.
- `TRANSPARENT`, default 8'h00: drawer colour that is never written.

Ports:
- `clk_draw` in 1: draw clock. This is the only clock.
- `rst_draw` in 1: asynchronous, active-high reset.
- `line_start` in 1: single-cycle pulse, already synchronised into `clk_draw`. Requests a bank swap.
- `bg_colour` in 8: background colour, sampled on `line_start`.
- `draw_valid` in 1: drawer pixel valid.
- `draw_ready` out 1: controller accepts the pixel.
- `draw_x` in 10: pixel x coordinate.
- `draw_colour` in 8: pixel colour.
- `draw_done` in 1: pulse, drawer finished the current line.
- `line_req` out 1: pulse, drawer may start rendering the next line.
- `bank_pix` out 1: bank the pixel side reads. Drives `addr_pix[10]`.
- `addr_draw` out 11, `we_draw` out 1, `colour_draw` out 8: BRAM write port, registered.
- `overrun` out 1: pulse, a line was swapped while still unfinished.
- `overrun_cnt` out 8: saturating count of overruns.

## Operation
- Internal `bank_draw`; `bank_pix` = ~`bank_draw` at all times. Addresses are {`bank_draw`, x}.
- States:
  - IDLE: wait for `line_start`.
  - CLEAR: issue one write per cycle of `bg_colour` at x = 0 … LINE_W-1. `draw_ready`=0.
  - DRAW: `draw_ready` = ~`line_start`.
  - DONE: wait for `line_start`.
- Transitions:
  - Any state on `line_start`: toggle `bank_draw`, latch `bg_colour`, reset the clear counter to 0, go to CLEAR.
  - CLEAR after writing x=LINE_W-1: go to DRAW and pulse `line_req` in the first DRAW cycle.
  - DRAW on `draw_done`: go to DONE.
- Drawer handshake: a pixel transfers when `draw_valid & draw_ready`. It produces a write unless `draw_colour`==`TRANSPARENT` or `draw_x` ≥ LINE_W; in both cases the pixel is consumed silently.
- Overrun:
  - Fires when `line_start` arrives in CLEAR, or in DRAW without a same-cycle `draw_done`.
  - Response: pulse `overrun`, increment `overrun_cnt` (saturates at 255), swap anyway. A partially drawn bank is displayed as-is.
  - `line_start` in IDLE or DONE is not an overrun.
- Simultaneous `line_start` and `draw_done` in DRAW: the swap wins, with no overrun.
- `draw_ready` is forced low in the `line_start` cycle, so no pixel lands in the bank being handed to the pixel side.

## Timing
- Reset values:
  - State: IDLE, `bank_draw`=0, `bank_pix`=1.
  - Outputs: `we_draw`=0, `addr_draw`=0, `colour_draw`=0, `line_req`=0, `overrun`=0, `overrun_cnt`=0, `draw_ready`=0.
- Reset mid-line aborts the clear or draw immediately; no further writes are issued.
- `bank_pix` and `bank_draw` change on the clock edge that samples `line_start`.
- Clear timing, with `line_start` sampled at edge 0:
  - CLEAR occupies cycles 1…LINE_W.
  - `we_draw` is high in cycles 2…LINE_W+1, one write per cycle, addresses contiguous.
  - DRAW starts at cycle LINE_W+1, with `line_req` high for that cycle only.
- Draw write latency: handshake at edge n gives `we_draw` high in the cycle after edge n. Throughput is one pixel per cycle.
- `draw_ready` is combinational from state and `line_start`. The drawer must not depend combinationally on it for `draw_valid`.
- `overrun` asserts the cycle after the offending `line_start`; `overrun_cnt` updates on the same edge.
- `line_start` during CLEAR restarts the clear from x=0 in the other bank; the remaining old clear writes are not issued.

## Structure
- Shared package `linebuffer_pkg` holds:
  - state enum `lb_state_t` {IDLE, CLEAR, DRAW, DONE};
  - `LB_ADDR_W`=11, `LB_X_W`=10;
  - `colour_t` = logic [7:0].
- No sub-module. The parent instantiates this block beside `linebuffer_bram` and ties `addr_pix[10]` to `bank_pix`.

## Test plan
- **Reset, then first line:** reset, `line_start`, LINE_W=8, `bg_colour`=8'h11. Expect `bank_pix`=0 and eight writes of 8'h11 to 11'h400…11'h407. `line_req` pulses in cycle 9; `draw_ready`=1 from cycle 9.
- **Drawer writes:** pixels (x=3, 8'h2A), (x=5, 8'h00), (x=9, 8'h33). Expect exactly one write, 8'h2A at 11'h403; all three handshakes complete.
- **Normal swap:** `draw_done`, then `line_start`. Expect `bank_pix`=1, a clear to 11'h000…11'h007, and `overrun` stays 0.
- **Overrun in DRAW:** `line_start` mid-DRAW with `draw_valid` held high. Expect `draw_ready`=0 that cycle, `overrun` pulses, `overrun_cnt`=1, and no write to the old bank after the swap.
- **Swap during CLEAR:** `line_start` after three clear writes. Expect the clear to restart at x=0 in the other bank, `overrun_cnt` increments, and `line_req` does not pulse until the new clear completes.
- **Counter saturation and async reset:** 260 overruns give `overrun_cnt`=255. Asserting `rst_draw` mid-CLEAR drops `we_draw` without waiting for a clock edge.
